// File: rtl/blink_sequencer.sv
// rtl/blink_sequencer.sv - shared-prescaler multi-channel LED blink controller
//
// One prescaler produces a common tick. Each of NUM_CH channels toggles its
// led output every period[i] ticks while enabled. Periods and enables are
// written at run time through a valid/ready config port.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   cfg_valid   config request valid
//   cfg_ready   config request accepted this cycle when high with cfg_valid
//   cfg_ch      target channel index
//   cfg_period  toggle period in ticks (0 = channel off)
//   cfg_en      channel enable
//   cfg_err     one-cycle pulse when an accepted write targets a missing channel
//   tick        one-cycle strobe, once per PRESCALE clocks
//   led         per-channel blink outputs
module blink_sequencer #(
  parameter int NUM_CH   = 5,
  parameter int PRESCALE = 750,
  parameter int CNT_W    = 16,
  parameter int CH_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic              tick,
  output logic [NUM_CH-1:0] led
);

  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {
    IDLE,
    APPLY
  } state_t;

  state_t state;
  state_t next_state;

  logic [PC_W-1:0]   pc;
  logic              wrap;
  logic              accept;
  logic [NUM_CH-1:0] apply_hit;

  logic [CH_W-1:0]   lat_ch;
  logic [CNT_W-1:0]  lat_period;
  logic              lat_en;

  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic              en     [NUM_CH];

  assign wrap = (pc == PC_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // cfg_ready is held low during reset so nothing is captured while rst is high.
  always_comb begin
    next_state = state;
    cfg_ready  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = !rst;
        accept    = cfg_valid && !rst;
        if (accept) begin
          next_state = APPLY;
        end
      end
      APPLY: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // An out-of-range latched channel matches no index, so APPLY writes nothing.
  always_comb begin
    apply_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state == APPLY && lat_ch == CH_W'(i)) begin
        apply_hit[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      tick       <= 1'b0;
      cfg_err    <= 1'b0;
      led        <= '0;
      lat_ch     <= '0;
      lat_period <= '0;
      lat_en     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
        en[i]     <= 1'b0;
      end
    end else begin
      pc   <= wrap ? '0 : pc + PC_W'(1);
      tick <= wrap;
      // Registered at the accept edge so the pulse lands on the APPLY cycle.
      cfg_err <= accept && (int'(cfg_ch) >= NUM_CH);
      if (accept) begin
        lat_ch     <= cfg_ch;
        lat_period <= cfg_period;
        lat_en     <= cfg_en;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        // A config write takes priority over a coincident wrap on its channel.
        if (apply_hit[i]) begin
          period[i] <= lat_period;
          en[i]     <= lat_en;
          cnt[i]    <= '0;
          led[i]    <= 1'b0;
        end else if (wrap) begin
          if (en[i] && period[i] != '0) begin
            if (cnt[i] == period[i] - CNT_W'(1)) begin
              cnt[i] <= '0;
              led[i] <= ~led[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end else begin
            cnt[i] <= '0;
            led[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb/tb_blink_sequencer.sv - directed self-checking bench for blink_sequencer
module tb_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_ch;
  logic [7:0] cfg_period;
  logic       cfg_en;
  logic       cfg_err;
  logic       tick;
  logic [4:0] led;

  int edges = 0;
  int rel   = 0;
  int cyc   = 0;
  int checks = 0;
  int passed = 0;

  blink_sequencer #(
    .NUM_CH(5),
    .PRESCALE(4),
    .CNT_W(8),
    .CH_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_en(cfg_en),
    .cfg_err(cfg_err),
    .tick(tick),
    .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Cycle 1 is the cycle following the last reset edge; samples are taken on negedges.
  task automatic adv();
    @(negedge clk);
    cyc = edges - rel + 1;
  endtask

  function automatic logic exp_tick(int c);
    return (c >= 5) && (c % 4 == 1);
  endfunction

  // Hand-derived led timeline for the main run (cycles 1..160).
  // ch0 p3 applied end of 22: toggles at 33,45,57,...; cleared at 113 by the en=0 rewrite.
  // ch1 p1 applied on wrap edge 72 (tick lost): toggles at 77,81,...
  // ch4 p2 applied end of 74: toggles at 81,89,...
  function automatic logic [4:0] exp_led(int c);
    logic [4:0] e;
    e = '0;
    if (c >= 33 && c <= 112 && ((c - 33) / 12) % 2 == 0) e[0] = 1'b1;
    if (c >= 77 && ((c - 77) / 4) % 2 == 0) e[1] = 1'b1;
    if (c >= 81 && ((c - 81) / 8) % 2 == 0) e[4] = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_period = '0;
    cfg_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", cfg_ready);
    else passed++;
    checks++;
    if (led !== 5'b0 || tick !== 1'b0 || cfg_err !== 1'b0)
      $display("FAIL reset_outs got led=%b tick=%b err=%b exp=0", led, tick, cfg_err);
    else passed++;
    rst = 1'b0;
    rel = edges;
    cyc = 1;
    #1;
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL ready_cycle1 got=%b exp=1", cfg_ready);
    else passed++;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) adv();
      checks++;
      if (tick !== exp_tick(cyc)) $display("FAIL idle_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick(cyc));
      else passed++;
      checks++;
      if (led !== 5'b0) $display("FAIL idle_led cyc=%0d got=%b exp=00000", cyc, led);
      else passed++;
    end
  endtask

  task automatic test_single_channel();
    while (cyc < 70) begin
      adv();
      case (cyc)
        21: begin
          checks++;
          if (cfg_ready !== 1'b1) $display("FAIL ch0_ready_acc cyc=%0d got=%b exp=1", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd3; cfg_en = 1'b1;
        end
        22: begin
          checks++;
          if (cfg_ready !== 1'b0) $display("FAIL ch0_ready_apply cyc=%0d got=%b exp=0", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b0;
        end
        23: begin
          checks++;
          if (cfg_ready !== 1'b1) $display("FAIL ch0_ready_back cyc=%0d got=%b exp=1", cyc, cfg_ready);
          else passed++;
        end
        default: ;
      endcase
      checks++;
      if (led !== exp_led(cyc)) $display("FAIL ch0_led cyc=%0d got=%b exp=%b", cyc, led, exp_led(cyc));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    while (cyc < 100) begin
      adv();
      case (cyc)
        71: begin
          checks++;
          if (cfg_ready !== 1'b1) $display("FAIL b2b_ready1 cyc=%0d got=%b exp=1", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_period = 8'd1; cfg_en = 1'b1;
        end
        72: begin
          checks++;
          if (cfg_ready !== 1'b0) $display("FAIL b2b_apply1 cyc=%0d got=%b exp=0", cyc, cfg_ready);
          else passed++;
          cfg_ch = 3'd4; cfg_period = 8'd2;
        end
        73: begin
          checks++;
          if (cfg_ready !== 1'b1) $display("FAIL b2b_ready2 cyc=%0d got=%b exp=1", cyc, cfg_ready);
          else passed++;
        end
        74: begin
          checks++;
          if (cfg_ready !== 1'b0) $display("FAIL b2b_apply2 cyc=%0d got=%b exp=0", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b0;
        end
        default: ;
      endcase
      checks++;
      if (cfg_err !== 1'b0) $display("FAIL b2b_err cyc=%0d got=%b exp=0", cyc, cfg_err);
      else passed++;
      checks++;
      if (led !== exp_led(cyc)) $display("FAIL b2b_led cyc=%0d got=%b exp=%b", cyc, led, exp_led(cyc));
      else passed++;
    end
  endtask

  task automatic test_bad_channel();
    while (cyc < 110) begin
      adv();
      case (cyc)
        101: begin
          checks++;
          if (cfg_ready !== 1'b1) $display("FAIL bad_ready cyc=%0d got=%b exp=1", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b1; cfg_ch = 3'd6; cfg_period = 8'd5; cfg_en = 1'b1;
        end
        102: cfg_valid = 1'b0;
        default: ;
      endcase
      checks++;
      if (cfg_err !== (cyc == 102)) $display("FAIL bad_err cyc=%0d got=%b exp=%b", cyc, cfg_err, cyc == 102);
      else passed++;
      checks++;
      if (led !== exp_led(cyc)) $display("FAIL bad_led cyc=%0d got=%b exp=%b", cyc, led, exp_led(cyc));
      else passed++;
    end
  endtask

  task automatic test_rewrite_on_wrap();
    while (cyc < 160) begin
      adv();
      case (cyc)
        111: begin
          cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd3; cfg_en = 1'b0;
        end
        112: begin
          checks++;
          if (cfg_ready !== 1'b0) $display("FAIL rw_apply cyc=%0d got=%b exp=0", cyc, cfg_ready);
          else passed++;
          cfg_valid = 1'b0;
        end
        141: begin
          cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_period = 8'd0; cfg_en = 1'b1;
        end
        142: cfg_valid = 1'b0;
        default: ;
      endcase
      checks++;
      if (cfg_err !== 1'b0) $display("FAIL rw_err cyc=%0d got=%b exp=0", cyc, cfg_err);
      else passed++;
      checks++;
      if (led !== exp_led(cyc)) $display("FAIL rw_led cyc=%0d got=%b exp=%b", cyc, led, exp_led(cyc));
      else passed++;
    end
  endtask

  task automatic test_reset_mid_apply();
    adv();
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_period = 8'd1; cfg_en = 1'b1;
    adv();
    rst = 1'b1;
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL rst_mid_ready got=%b exp=0", cfg_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    rel = edges;
    cyc = 1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) adv();
      checks++;
      if (tick !== exp_tick(cyc)) $display("FAIL rst_mid_tick cyc=%0d got=%b exp=%b", cyc, tick, exp_tick(cyc));
      else passed++;
      checks++;
      if (led !== 5'b0 || cfg_err !== 1'b0)
        $display("FAIL rst_mid_outs cyc=%0d got led=%b err=%b exp led=00000 err=0", cyc, led, cfg_err);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_back_to_back();
    test_bad_channel();
    test_rewrite_on_wrap();
    test_reset_mid_apply();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
